// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and a small decode helper, shared
// by the sync generator and the downstream pixel generators.
`timescale 1ns/1ps
package vga_timing_pkg;

    localparam int unsigned DEF_H_VIS  = 640;
    localparam int unsigned DEF_H_FP   = 16;
    localparam int unsigned DEF_H_SYNC = 96;
    localparam int unsigned DEF_H_BP   = 48;
    localparam int unsigned DEF_V_VIS  = 480;
    localparam int unsigned DEF_V_FP   = 10;
    localparam int unsigned DEF_V_SYNC = 2;
    localparam int unsigned DEF_V_BP   = 33;

    localparam int unsigned DEF_H_TOT = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOT = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    localparam int unsigned DEF_H_SYNC_START = DEF_H_VIS + DEF_H_FP;
    localparam int unsigned DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC - 1;
    localparam int unsigned DEF_V_SYNC_START = DEF_V_VIS + DEF_V_FP;
    localparam int unsigned DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC - 1;

    // Inclusive range test on a 10-bit screen coordinate.
    function automatic logic in_span(input logic [9:0] pos,
                                     input logic [9:0] first,
                                     input logic [9:0] last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Mod-DIV clock divider producing a one-clk pixel tick every DIV clocks.
`timescale 1ns/1ps
module pixel_tick_div #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int unsigned W = $clog2(DIV);
    localparam logic [W-1:0] LAST = W'(DIV - 1);
    localparam logic [W-1:0] PRE  = W'(DIV - 2);

    logic [W-1:0] div_cnt;

    // p_tick is registered: it is set on the edge where div_cnt enters DIV-1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
            p_tick  <= 1'b0;
        end else begin
            div_cnt <= (div_cnt == LAST) ? '0 : div_cnt + W'(1);
            p_tick  <= (div_cnt == PRE);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered sync and
// blanking decode, all aligned to the registered pixel coordinates.
`timescale 1ns/1ps
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned DIV    = 4,
    parameter int unsigned H_VIS  = vga_timing_pkg::DEF_H_VIS,
    parameter int unsigned H_FP   = vga_timing_pkg::DEF_H_FP,
    parameter int unsigned H_SYNC = vga_timing_pkg::DEF_H_SYNC,
    parameter int unsigned H_BP   = vga_timing_pkg::DEF_H_BP,
    parameter int unsigned V_VIS  = vga_timing_pkg::DEF_V_VIS,
    parameter int unsigned V_FP   = vga_timing_pkg::DEF_V_FP,
    parameter int unsigned V_SYNC = vga_timing_pkg::DEF_V_SYNC,
    parameter int unsigned V_BP   = vga_timing_pkg::DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_tick
);

    localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_VIS + V_FP + V_SYNC - 1);

    logic [9:0] h_q, v_q;
    logic [9:0] h_next, v_next;

    pixel_tick_div #(.DIV(DIV)) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    always_comb begin
        h_next = h_q + 10'd1;
        v_next = v_q;
        if (h_q == H_LAST) begin
            h_next = '0;
            v_next = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    // Decode from the next coordinates so the flags land on the same edge as
    // the counters; video_on stays low over the first pixel after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_q      <= '0;
            v_q      <= '0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
        end else if (p_tick) begin
            h_q      <= h_next;
            v_q      <= v_next;
            hsync    <= !in_span(h_next, HS_FIRST, HS_LAST);
            vsync    <= !in_span(v_next, VS_FIRST, VS_LAST);
            video_on <= (h_next < H_VIS_W) && (v_next < V_VIS_W);
        end
    end

    assign pixel_x    = h_q;
    assign pixel_y    = v_q;
    assign frame_tick = p_tick && (h_q == H_LAST) && (v_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: default-timing instance plus a shrunk DIV=2 instance,
// both compared every clock against an arithmetic timing model.
`timescale 1ns/1ps
module tb_vga_sync_gen;

    localparam int A_DIV = 4;
    localparam int A_HV = 640, A_HFP = 16, A_HS = 96, A_HBP = 48;
    localparam int A_VV = 480, A_VFP = 10, A_VS = 2,  A_VBP = 33;
    localparam int B_DIV = 2;
    localparam int B_HV = 16,  B_HFP = 4,  B_HS = 6,  B_HBP = 6;
    localparam int B_VV = 12,  B_VFP = 2,  B_VS = 2,  B_VBP = 4;
    localparam int B_FRAME = (B_HV + B_HFP + B_HS + B_HBP) * (B_VV + B_VFP + B_VS + B_VBP) * B_DIV;

    logic clk = 1'b0;
    logic rst_a = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    logic       p_tick_a, hsync_a, vsync_a, video_on_a, frame_tick_a;
    logic [9:0] pixel_x_a, pixel_y_a;
    logic       p_tick_b, hsync_b, vsync_b, video_on_b, frame_tick_b;
    logic [9:0] pixel_x_b, pixel_y_b;

    vga_sync_gen u_dut_a (
        .clk(clk), .reset(rst_a), .p_tick(p_tick_a),
        .pixel_x(pixel_x_a), .pixel_y(pixel_y_a),
        .hsync(hsync_a), .vsync(vsync_a), .video_on(video_on_a),
        .frame_tick(frame_tick_a)
    );

    vga_sync_gen #(
        .DIV(B_DIV), .H_VIS(B_HV), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_VIS(B_VV), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP)
    ) u_dut_b (
        .clk(clk), .reset(rst_b), .p_tick(p_tick_b),
        .pixel_x(pixel_x_b), .pixel_y(pixel_y_b),
        .hsync(hsync_b), .vsync(vsync_b), .video_on(video_on_b),
        .frame_tick(frame_tick_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit run_checks = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs after k clock edges since reset release: pixel index is
    // k/div, coordinates follow from it, flags are decoded straight from the
    // timing parameters. Packed as {pt, ft, hs, vs, von, x, y}.
    function automatic logic [31:0] model(input longint k, input longint div,
                                          input longint hv, input longint hfp,
                                          input longint hs, input longint hbp,
                                          input longint vv, input longint vfp,
                                          input longint vs, input longint vbp);
        longint ht, vt, n, x, y;
        logic pt, ft, hsy, vsy, von;
        ht  = hv + hfp + hs + hbp;
        vt  = vv + vfp + vs + vbp;
        n   = k / div;
        x   = n % ht;
        y   = (n / ht) % vt;
        pt  = (k % div) == div - 1;
        hsy = !((x >= hv + hfp) && (x < hv + hfp + hs));
        vsy = !((y >= vv + vfp) && (y < vv + vfp + vs));
        von = (n != 0) && (x < hv) && (y < vv);
        ft  = pt && (x == ht - 1) && (y == vt - 1);
        return {7'b0, pt, ft, hsy, vsy, von, 10'(x), 10'(y)};
    endfunction

    longint k_a = 0, k_b = 0;
    always @(posedge clk or negedge rst_a) k_a <= (!rst_a) ? 0 : k_a + 1;
    always @(posedge clk or negedge rst_b) k_b <= (!rst_b) ? 0 : k_b + 1;

    int epoch_a = 0, epoch_b = 0;
    int hs_low_a = 0, vs_low_b = 0, ft_b0 = 0, ft_b1 = 0;

    always @(negedge clk) begin
        if (run_checks) begin
            check_eq("align_a",
                     {7'b0, p_tick_a, frame_tick_a, hsync_a, vsync_a, video_on_a, pixel_x_a, pixel_y_a},
                     model(k_a, A_DIV, A_HV, A_HFP, A_HS, A_HBP, A_VV, A_VFP, A_VS, A_VBP));
            check_eq("align_b",
                     {7'b0, p_tick_b, frame_tick_b, hsync_b, vsync_b, video_on_b, pixel_x_b, pixel_y_b},
                     model(k_b, B_DIV, B_HV, B_HFP, B_HS, B_HBP, B_VV, B_VFP, B_VS, B_VBP));
        end
        if (rst_a && epoch_a == 0 && k_a >= 3200 && k_a < 6400 && !hsync_a) hs_low_a++;
        if (rst_b && epoch_b == 0 && k_b < B_FRAME && !vsync_b) vs_low_b++;
        if (rst_b && epoch_b == 0 && k_b < B_FRAME && frame_tick_b) ft_b0++;
        if (rst_b && epoch_b == 1 && k_b < 2 * B_FRAME && frame_tick_b) ft_b1++;
    end

    task automatic go_a(input longint target);
        int guard = 0;
        while (k_a < target && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("reach_k_a", 32'(k_a), 32'(target));
    endtask

    task automatic go_b(input longint target);
        int guard = 0;
        while (k_b < target && guard < 20000) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("reach_k_b", 32'(k_b), 32'(target));
    endtask

    task automatic first_tick_a(input string tag);
        int edges = 0;
        for (int i = 1; i <= 10 && edges == 0; i++) begin
            @(posedge clk); #1;
            if (p_tick_a) edges = i;
        end
        check_eq({tag, "_ptick_edge"}, 32'(edges), 32'(A_DIV - 1));
        @(posedge clk); #1;
        check_eq({tag, "_x_after_tick"}, 32'(pixel_x_a), 32'd1);
    endtask

    task automatic expect_reset_a(input string tag);
        check_eq({tag, "_x"},   32'(pixel_x_a), 32'd0);
        check_eq({tag, "_y"},   32'(pixel_y_a), 32'd0);
        check_eq({tag, "_hs"},  32'(hsync_a), 32'd1);
        check_eq({tag, "_vs"},  32'(vsync_a), 32'd1);
        check_eq({tag, "_von"}, 32'(video_on_a), 32'd0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fork
            begin : seq_a
                longint tgt;
                repeat (5) @(posedge clk);
                #1 expect_reset_a("in_reset");
                @(negedge clk) rst_a = 1'b1;
                first_tick_a("release");

                go_a(639 * 4 + 3);
                check_eq("von_at_639", 32'(video_on_a), 32'd1);
                go_a(640 * 4);
                check_eq("von_at_640", 32'(video_on_a), 32'd0);
                go_a(3199);
                check_eq("wrap_x_799", 32'(pixel_x_a), 32'd799);
                check_eq("wrap_y_0",   32'(pixel_y_a), 32'd0);
                go_a(3200);
                check_eq("wrap_x_0",   32'(pixel_x_a), 32'd0);
                check_eq("wrap_y_1",   32'(pixel_y_a), 32'd1);
                go_a(6401);
                check_eq("hsync_low_clks", 32'(hs_low_a), 32'd384);

                tgt = (2 * 800 + 700) * 4 + longint'($urandom_range(0, 3));
                go_a(tgt);
                check_eq("pre_rst_x",  32'(pixel_x_a), 32'd700);
                check_eq("pre_rst_hs", 32'(hsync_a), 32'd0);
                #2 rst_a = 1'b0;
                epoch_a = 1;
                #1 expect_reset_a("async_rst");
                repeat ($urandom_range(1, 6)) @(posedge clk);
                @(negedge clk) rst_a = 1'b1;
                first_tick_a("rerelease");
                go_a(900 * 4);
                check_eq("after_rst_y1", 32'(pixel_y_a), 32'd1);
            end
            begin : seq_b
                longint tgt;
                repeat (3) @(posedge clk);
                @(negedge clk) rst_b = 1'b1;
                go_b(B_FRAME - 1);
                check_eq("b_last_ft", 32'(frame_tick_b), 32'd1);
                check_eq("b_last_x",  32'(pixel_x_b), 32'd31);
                check_eq("b_last_y",  32'(pixel_y_b), 32'd19);
                go_b(B_FRAME);
                check_eq("b_new_x",   32'(pixel_x_b), 32'd0);
                check_eq("b_new_y",   32'(pixel_y_b), 32'd0);
                check_eq("b_new_von", 32'(video_on_b), 32'd1);
                go_b(B_FRAME + 1);
                check_eq("b_frame_ticks", 32'(ft_b0), 32'd1);
                check_eq("b_vsync_low",   32'(vs_low_b), 32'd128);

                tgt = B_FRAME + 20 + longint'($urandom_range(0, 1100));
                go_b(tgt);
                #2 rst_b = 1'b0;
                epoch_b = 1;
                #1;
                check_eq("b_async_x",  32'(pixel_x_b), 32'd0);
                check_eq("b_async_y",  32'(pixel_y_b), 32'd0);
                check_eq("b_async_hs", 32'(hsync_b), 32'd1);
                repeat ($urandom_range(1, 5)) @(posedge clk);
                @(negedge clk) rst_b = 1'b1;
                @(posedge clk); #1;
                check_eq("b_first_ptick", 32'(p_tick_b), 32'd1);
                go_b(2 * B_FRAME + 1);
                check_eq("b_frame_ticks_2", 32'(ft_b1), 32'd2);
            end
        join
        run_checks = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
